// File: rtl/s_key_pkg.sv
// Shared definitions for the sequential AES-128 key expansion engine.
// Contents: word/round-key typedefs, round count, the Rcon table with a
// lookup helper, and the controller state encoding.
package s_key_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  localparam int NUM_ROUNDS = 10;

  // Round constants for rounds 1..10 (top byte of the Rcon word).
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_e;

  // Rcon word for round r; rounds outside 1..10 yield zero.
  function automatic word_t rcon_word(input logic [3:0] r);
    word_t w;
    w = '0;
    for (int i = 1; i <= 10; i++)
      if (r == 4'(i)) w = {RCON[i], 24'h000000};
    return w;
  endfunction

endpackage

// File: rtl/s_sub_word.sv
// AES SubWord: four independent S-box byte substitutions on a 32-bit word.
// Ports:
//   word_i  in  32  input word
//   word_o  out 32  S-box applied to each byte
module s_sub_word
  import s_key_pkg::*;
(
  input  word_t word_i,
  output word_t word_o
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign word_o[8*b +: 8] = SBOX[word_i[8*b +: 8]];
  end

endmodule

// File: rtl/s_key_expand_seq.sv
// Sequential AES-128 key expansion engine with an 11-entry round-key store.
// Accepts one cipher key, derives round keys 1..10 at one per clock, and
// serves any stored round key through a registered indexed read port.
// Optional feature: define KEY_ZEROIZE_EN to make `zeroize` clear all key
// material and abort expansion; otherwise `zeroize` is ignored.
// Ports:
//   clk         in   1    clock, rising edge
//   rst         in   1    asynchronous reset, active-high
//   key_in      in   128  cipher key, word0 = [127:96]
//   key_valid   in   1    key_in valid
//   key_ready   out  1    engine can accept a key
//   keys_valid  out  1    store holds a complete schedule for the last key
//   rk_rd_idx   in   4    round-key index to read (0..10, others read 0)
//   rk_rd_data  out  128  registered round key, 1-cycle latency
//   zeroize     in   1    clear key material (KEY_ZEROIZE_EN only)
module s_key_expand_seq #(
  parameter int KEY_W      = 128,
  parameter int NUM_ROUNDS = s_key_pkg::NUM_ROUNDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             keys_valid,
  input  logic [3:0]       rk_rd_idx,
  output logic [KEY_W-1:0] rk_rd_data,
  input  logic             zeroize
);
  import s_key_pkg::*;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic kv_q, kv_d;
  rkey_t rk_q [NUM_ROUNDS+1];
  rkey_t rk_d [NUM_ROUNDS+1];
  rkey_t rd_q, rd_d;

  // Previous round key rk[cnt-1] feeds the recurrence.
  rkey_t prev;
  word_t p0, p1, p2, p3, sub, w0, w1, w2, w3;
  rkey_t rk_next;

  always_comb begin
    prev = '0;
    for (int i = 0; i < NUM_ROUNDS; i++)
      if (cnt_q == 4'(i + 1)) prev = rk_q[i];
  end

  assign {p0, p1, p2, p3} = prev;

  s_sub_word u_sub_word (
    .word_i ({p3[23:0], p3[31:24]}),
    .word_o (sub)
  );

  assign w0      = p0 ^ sub ^ rcon_word(cnt_q);
  assign w1      = p1 ^ w0;
  assign w2      = p2 ^ w1;
  assign w3      = p3 ^ w2;
  assign rk_next = {w0, w1, w2, w3};

`ifndef KEY_ZEROIZE_EN
  logic unused_zeroize;
  assign unused_zeroize = zeroize;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kv_d    = kv_q;
    rk_d    = rk_q;

    // Read samples the store before this edge's write: no bypass.
    rd_d = '0;
    for (int i = 0; i <= NUM_ROUNDS; i++)
      if (rk_rd_idx == 4'(i)) rd_d = rk_q[i];

    case (state_q)
      IDLE, READY: begin
        if (key_valid) begin
          rk_d[0] = key_in;
          cnt_d   = 4'd1;
          kv_d    = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        for (int i = 1; i <= NUM_ROUNDS; i++)
          if (cnt_q == 4'(i)) rk_d[i] = rk_next;
        if (cnt_q == 4'(NUM_ROUNDS)) begin
          cnt_d   = 4'd0;
          kv_d    = 1'b1;
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef KEY_ZEROIZE_EN
    // Zeroize overrides any accept or expansion step on the same edge.
    if (zeroize) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      kv_d    = 1'b0;
      rd_d    = '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_d[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      kv_q    <= 1'b0;
      rd_q    <= '0;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kv_q    <= kv_d;
      rd_q    <= rd_d;
      for (int i = 0; i <= NUM_ROUNDS; i++) rk_q[i] <= rk_d[i];
    end
  end

  assign key_ready  = (state_q != EXPAND);
  assign keys_valid = kv_q;
  assign rk_rd_data = rd_q;

endmodule

// File: tb/tb_s_key_expand_seq.sv
module tb_s_key_expand_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         keys_valid;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
  logic         zeroize;

  int tests = 0;
  int fails = 0;

  // Expected read data, pushed when an index is driven, popped after the edge.
  logic [127:0] sb [$];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  s_key_expand_seq dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data),
    .zeroize    (zeroize)
  );

  always #5 clk = ~clk;

  // Present one key for a single edge, then wait (bounded) for keys_valid.
  task automatic load_key(input logic [127:0] k);
    int n;
    @(negedge clk);
    key_in    = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    n = 0;
    while (!keys_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (keys_valid !== 1'b1) begin
      fails++;
      $display("FAIL load_key_timeout: keys_valid=%b expected 1", keys_valid);
    end
  endtask

  // Drive one read index and queue its expected data.
  task automatic drive_read(input logic [3:0] idx, input logic [127:0] exp);
    @(negedge clk);
    rk_rd_idx = idx;
    sb.push_back(exp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if (key_ready !== 1'b1) begin fails++; $display("FAIL reset_key_ready: got %b exp 1", key_ready); end
    tests++;
    if (keys_valid !== 1'b0) begin fails++; $display("FAIL reset_keys_valid: got %b exp 0", keys_valid); end
    tests++;
    if (rk_rd_data !== '0) begin fails++; $display("FAIL reset_rd_data: got %h exp 0", rk_rd_data); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive_read(4'd0, '0);
    @(posedge clk); #1;
    begin
      logic [127:0] e;
      e = sb.pop_front();
      tests++;
      if (rk_rd_data !== e) begin fails++; $display("FAIL reset_store_rk0: got %h exp %h", rk_rd_data, e); end
    end
  endtask

  task automatic test_fips();
    logic [127:0] e;
    load_key(K1);
    for (int i = 0; i <= 10; i++) begin
      drive_read(4'(i), K1_RK[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (rk_rd_data !== e) begin fails++; $display("FAIL fips_rk%0d: got %h exp %h", i, rk_rd_data, e); end
    end
  endtask

  task automatic test_latency();
    logic [127:0] e;
    @(negedge clk);
    key_in = K1; key_valid = 1'b1;
    @(posedge clk); #1;  // E0
    tests++;
    if (key_ready !== 1'b0 || keys_valid !== 1'b0) begin
      fails++; $display("FAIL lat_E0: ready=%b valid=%b exp 0 0", key_ready, keys_valid);
    end
    key_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 3) begin key_in = '0; key_valid = 1'b1; end  // must be ignored
      if (c == 4) key_valid = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (keys_valid !== (c == 10) || key_ready !== (c == 10)) begin
        fails++;
        $display("FAIL lat_E%0d: valid=%b ready=%b exp %b %b", c, keys_valid, key_ready, c == 10, c == 10);
      end
    end
    drive_read(4'd10, K1_RK[10]);
    drive_read(4'd0, K1_RK[0]);  // back-to-back: first result arrives now
    #1;
    // The index-10 result appeared on the edge between the two drives.
    begin end
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e && rk_rd_data !== K1_RK[0]) begin
      fails++; $display("FAIL lat_rk_order: got %h", rk_rd_data);
    end
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e) begin fails++; $display("FAIL lat_ignored_rk0: got %h exp %h", rk_rd_data, e); end
    drive_read(4'd10, K1_RK[10]);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e) begin fails++; $display("FAIL lat_ignored_rk10: got %h exp %h", rk_rd_data, e); end
  endtask

  task automatic test_zero_key();
    logic [127:0] e;
    load_key('0);
    drive_read(4'd1, Z_RK1);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e) begin fails++; $display("FAIL zero_rk1: got %h exp %h", rk_rd_data, e); end
    drive_read(4'd10, Z_RK10);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e) begin fails++; $display("FAIL zero_rk10: got %h exp %h", rk_rd_data, e); end
  endtask

  task automatic test_async_reset();
    logic [127:0] e;
    @(negedge clk);
    rk_rd_idx = 4'd0;
    key_in = K1; key_valid = 1'b1;
    @(posedge clk); #1;  // E0
    key_valid = 1'b0;
    repeat (5) @(posedge clk);  // E5
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (rk_rd_data !== '0 || keys_valid !== 1'b0 || key_ready !== 1'b1) begin
      fails++;
      $display("FAIL async_reset: data=%h valid=%b ready=%b exp 0 0 1", rk_rd_data, keys_valid, key_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    load_key('0);
    drive_read(4'd10, Z_RK10);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e) begin fails++; $display("FAIL async_reset_rekey: got %h exp %h", rk_rd_data, e); end
  endtask

  task automatic test_oob_back_to_back();
    logic [127:0] e;
    load_key(K1);
    for (int i = 11; i <= 15; i++) begin
      drive_read(4'(i), '0);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (rk_rd_data !== e) begin fails++; $display("FAIL oob_idx%0d: got %h exp %h", i, rk_rd_data, e); end
    end
    for (int i = 0; i <= 2; i++) begin
      drive_read(4'(i), K1_RK[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (rk_rd_data !== e) begin fails++; $display("FAIL b2b_idx%0d: got %h exp %h", i, rk_rd_data, e); end
    end
  endtask

  task automatic test_zeroize();
    logic [127:0] e;
    int n;
    @(negedge clk);
    rk_rd_idx = 4'd0;
    key_in = K1; key_valid = 1'b1;
    @(posedge clk); #1;  // E0
    key_valid = 1'b0;
    repeat (3) @(posedge clk);  // E3
    @(negedge clk);
    zeroize = 1'b1;
    @(posedge clk); #1;  // E4
    zeroize = 1'b0;
`ifdef KEY_ZEROIZE_EN
    repeat (12) @(posedge clk);
    #1;
    tests++;
    if (keys_valid !== 1'b0 || key_ready !== 1'b1) begin
      fails++; $display("FAIL zeroize_flags: valid=%b ready=%b exp 0 1", keys_valid, key_ready);
    end
    for (int i = 0; i <= 10; i++) begin
      drive_read(4'(i), '0);
      @(posedge clk); #1;
      e = sb.pop_front();
      tests++;
      if (rk_rd_data !== e) begin fails++; $display("FAIL zeroize_rk%0d: got %h exp %h", i, rk_rd_data, e); end
    end
`else
    n = 0;
    while (!keys_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (keys_valid !== 1'b1) begin fails++; $display("FAIL zeroize_ignored_valid: got %b exp 1", keys_valid); end
    drive_read(4'd10, K1_RK[10]);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e) begin fails++; $display("FAIL zeroize_ignored_rk10: got %h exp %h", rk_rd_data, e); end
    drive_read(4'd0, K1_RK[0]);
    @(posedge clk); #1;
    e = sb.pop_front();
    tests++;
    if (rk_rd_data !== e) begin fails++; $display("FAIL zeroize_ignored_rk0: got %h exp %h", rk_rd_data, e); end
`endif
  endtask

  initial begin
    key_in    = '0;
    key_valid = 1'b0;
    rk_rd_idx = 4'd0;
    zeroize   = 1'b0;
    test_reset();
    test_fips();
    test_latency();
    test_zero_key();
    test_async_reset();
    test_oob_back_to_back();
    test_zeroize();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
